// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: IF stage plus IF/ID pipeline register of the 5-stage RV32I core.
//
// Owns PC_F and issues fetches over a req/ready handshake. Responses come back in
// request order on rvalid and land in a 2-entry buffer. The buffer head is loaded
// into IF/ID, which drives decode.
//
// Ports:
//   clk, rst                     clock; asynchronous active-high reset
//   Stall_D, Flush_D             hazard unit: hold IF/ID / insert a bubble into IF/ID
//   PCSrc_E, PCTarget_E          EX-stage redirect and its target
//   Imem_Req/Addr/Ready          fetch request channel (Addr = PC_F)
//   Imem_RValid/RData            in-order read data return
//   Instr_D/PC_D/PCPlus4_D       IF/ID contents presented to decode
//   Valid_D                      Instr_D is a real instruction (0 = bubble)
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic        PCSrc_E,
  input  logic [31:0] PCTarget_E,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic        Imem_RValid,
  input  logic [31:0] Imem_RData,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] inf_pc_q [2];
  logic [31:0] inf_pc_d [2];
  logic [1:0]  inf_cnt_q, inf_cnt_d;
  logic [1:0]  discard_q, discard_d;
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_instr_d [2];
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_pc_d [2];
  logic [1:0]  buf_cnt_q, buf_cnt_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        resp_valid, resp_drop, resp_keep;
  logic        bubble, pop, accept;
  logic [2:0]  credit_used;

  // Handshake and credit. The slot freed by this cycle's IF/ID load counts as
  // available, which is what sustains one instruction per cycle with 1-cycle memory.
  always_comb begin
    resp_valid  = Imem_RValid && ((inf_cnt_q != 2'd0) || (discard_q != 2'd0));
    resp_drop   = resp_valid && (discard_q != 2'd0);
    resp_keep   = resp_valid && (discard_q == 2'd0);
    bubble      = PCSrc_E || Flush_D;
    pop         = !bubble && !Stall_D && (buf_cnt_q != 2'd0);
    credit_used = {1'b0, inf_cnt_q} + {1'b0, buf_cnt_q} + {1'b0, discard_q} - {2'b00, pop};
    Imem_Req    = !rst && !PCSrc_E && (credit_used < 3'd2);
    accept      = Imem_Req && Imem_Ready;
  end

  // PC_F, inflight-PC queue and discard counter.
  always_comb begin
    pc_f_d    = pc_f_q;
    inf_pc_d  = inf_pc_q;
    inf_cnt_d = inf_cnt_q;
    discard_d = discard_q;
    if (PCSrc_E) begin
      pc_f_d    = PCTarget_E;
      inf_cnt_d = 2'd0;
      // Everything still outstanding, less a response consumed this cycle, is stale.
      discard_d = discard_q + inf_cnt_q - {1'b0, resp_valid};
    end else begin
      if (resp_drop) begin
        discard_d = discard_q - 2'd1;
      end
      if (resp_keep) begin
        inf_pc_d[0] = inf_pc_q[1];
        inf_cnt_d   = inf_cnt_q - 2'd1;
      end
      if (accept) begin
        // Credit guarantees at most one entry remains after any pop.
        inf_pc_d[inf_cnt_d[0]] = pc_f_q;
        inf_cnt_d              = inf_cnt_d + 2'd1;
        pc_f_d                 = pc_f_q + 32'd4;
      end
    end
  end

  // Return buffer: pop to IF/ID first, then append the response behind what remains.
  always_comb begin
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_cnt_d   = buf_cnt_q;
    if (PCSrc_E) begin
      buf_cnt_d = 2'd0;
    end else begin
      if (pop) begin
        buf_instr_d[0] = buf_instr_q[1];
        buf_pc_d[0]    = buf_pc_q[1];
        buf_cnt_d      = buf_cnt_q - 2'd1;
      end
      if (resp_keep) begin
        buf_instr_d[buf_cnt_d[0]] = Imem_RData;
        buf_pc_d[buf_cnt_d[0]]    = inf_pc_q[0];
        buf_cnt_d                 = buf_cnt_d + 2'd1;
      end
    end
  end

  // IF/ID register: bubble beats stall, stall beats load.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (bubble) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (pop) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = buf_instr_q[0];
      ifid_pc_d    = buf_pc_q[0];
      ifid_pc4_d   = buf_pc_q[0] + 32'd4;
    end else if (!Stall_D) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_q       <= RESET_PC;
      inf_pc_q     <= '{default: '0};
      inf_cnt_q    <= 2'd0;
      discard_q    <= 2'd0;
      buf_instr_q  <= '{default: '0};
      buf_pc_q     <= '{default: '0};
      buf_cnt_q    <= 2'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_f_q       <= pc_f_d;
      inf_pc_q     <= inf_pc_d;
      inf_cnt_q    <= inf_cnt_d;
      discard_q    <= discard_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      buf_cnt_q    <= buf_cnt_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign Imem_Addr = pc_f_q;
  assign Instr_D   = ifid_instr_q;
  assign PC_D      = ifid_pc_q;
  assign PCPlus4_D = ifid_pc4_q;
  assign Valid_D   = ifid_valid_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
module tb_fetch_decode_stage;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Stall_D, Flush_D, PCSrc_E;
  logic [31:0] PCTarget_E;
  logic        Imem_Req, Imem_Ready, Imem_RValid;
  logic [31:0] Imem_Addr, Imem_RData;
  logic [31:0] Instr_D, PC_D, PCPlus4_D;
  logic        Valid_D;

  logic        Imem_Req2, Imem_RValid2, Valid_D2;
  logic [31:0] Imem_Addr2, Imem_RData2, Instr_D2, PC_D2, PCPlus4_D2;

  always #5 clk = ~clk;

  fetch_decode_stage dut (
    .clk(clk), .rst(rst), .Stall_D(Stall_D), .Flush_D(Flush_D), .PCSrc_E(PCSrc_E),
    .PCTarget_E(PCTarget_E), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Ready(Imem_Ready), .Imem_RValid(Imem_RValid), .Imem_RData(Imem_RData),
    .Instr_D(Instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .Valid_D(Valid_D)
  );

  fetch_decode_stage #(.RESET_PC(RST_PC2)) dut2 (
    .clk(clk), .rst(rst), .Stall_D(1'b0), .Flush_D(1'b0), .PCSrc_E(1'b0),
    .PCTarget_E(32'h0), .Imem_Req(Imem_Req2), .Imem_Addr(Imem_Addr2),
    .Imem_Ready(1'b1), .Imem_RValid(Imem_RValid2), .Imem_RData(Imem_RData2),
    .Instr_D(Instr_D2), .PC_D(PC_D2), .PCPlus4_D(PCPlus4_D2), .Valid_D(Valid_D2)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Memory model and reference program-order stream.
  int          cyc, last_due, lat_min, lat_max, delivered;
  logic [31:0] key;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_pc, exp_fetch;
  logic        prev_bubble, prev_hold, expect_no_req;
  logic        last_v;
  logic [31:0] last_i, last_pc, last_pc4;
  logic        r2_pend;
  logic [31:0] r2_addr;
  logic [31:0] acc2[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ key;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int lat;
    @(negedge clk);
    // IF/ID contents produced by the previous edge.
    if (prev_bubble) begin
      chk("bubble_valid", {31'b0, Valid_D}, 32'd0);
      chk("bubble_instr", Instr_D, NOP);
    end else if (prev_hold) begin
      chk("hold_valid", {31'b0, Valid_D}, {31'b0, last_v});
      chk("hold_instr", Instr_D, last_i);
      chk("hold_pc", PC_D, last_pc);
      chk("hold_pc4", PCPlus4_D, last_pc4);
    end else if (Valid_D) begin
      chk("stream_pc", PC_D, exp_pc);
      chk("stream_instr", Instr_D, word(exp_pc));
      chk("stream_pc4", PCPlus4_D, exp_pc + 32'd4);
      exp_pc += 32'd4;
      delivered++;
    end else begin
      chk("empty_instr", Instr_D, NOP);
    end
    // Fetch side.
    if (expect_no_req) chk("credit_req", {31'b0, Imem_Req}, 32'd0);
    if (PCSrc_E) begin
      chk("redirect_req", {31'b0, Imem_Req}, 32'd0);
      exp_fetch = PCTarget_E;
      exp_pc    = PCTarget_E;
    end else if (Imem_Req && Imem_Ready) begin
      chk("fetch_addr", Imem_Addr, exp_fetch);
      exp_fetch += 32'd4;
      lat = $urandom_range(lat_max, lat_min);
      if (cyc + lat > last_due) last_due = cyc + lat;
      pend_addr.push_back(Imem_Addr);
      pend_due.push_back(last_due);
    end
    // Second instance: always-ready 1-cycle memory returning address as data.
    if (Imem_Req2) begin
      if (acc2.size() < 3) acc2.push_back(Imem_Addr2);
      r2_pend = 1'b1;
      r2_addr = Imem_Addr2;
    end else begin
      r2_pend = 1'b0;
    end
    if (Valid_D2 && (PC_D2 == 32'hFFFF_FFFC)) chk("wrap_pc4", PCPlus4_D2, 32'd0);
    last_v      = Valid_D;
    last_i      = Instr_D;
    last_pc     = PC_D;
    last_pc4    = PCPlus4_D;
    prev_bubble = PCSrc_E || Flush_D;
    prev_hold   = Stall_D && !(PCSrc_E || Flush_D);
    @(posedge clk);
    #1;
    cyc++;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      Imem_RValid = 1'b1;
      Imem_RData  = word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      Imem_RValid = 1'b0;
      Imem_RData  = $urandom;
    end
    Imem_RValid2 = r2_pend;
    Imem_RData2  = r2_addr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    Stall_D = 1'b0; Flush_D = 1'b0; PCSrc_E = 1'b0;
    Imem_RValid = 1'b0; Imem_RValid2 = 1'b0;
    pend_addr.delete(); pend_due.delete(); acc2.delete();
    r2_pend = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, Valid_D}, 32'd0);
    chk("rst_instr", Instr_D, NOP);
    chk("rst_pc", PC_D, 32'd0);
    chk("rst_pc4", PCPlus4_D, 32'd0);
    chk("rst_req", {31'b0, Imem_Req}, 32'd0);
    chk("rst_addr", Imem_Addr, 32'd0);
    chk("rst_addr2", Imem_Addr2, RST_PC2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0; last_due = 0;
    exp_pc = 32'd0; exp_fetch = 32'd0;
    prev_bubble = 1'b0; prev_hold = 1'b0; expect_no_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0;
    logic        found;
    logic [31:0] addr0;
    Imem_Ready = 1'b1; PCTarget_E = 32'd0; Imem_RData = 32'd0; Imem_RData2 = 32'd0;
    key = 32'd0; delivered = 0; lat_min = 1; lat_max = 1;
    #2;
    do_reset();

    // 1: address-as-data stream, one instruction per cycle after the pipeline fills.
    d0 = delivered;
    repeat (20) cycle();
    chk("t1_throughput", 32'(delivered - d0), 32'd17);

    // 2: stall three cycles; requests stop, stream resumes without gap.
    key = 32'hC0DE_0000;
    do_reset();
    repeat (6) cycle();
    Stall_D = 1'b1;
    cycle();
    expect_no_req = 1'b1;
    cycle();
    cycle();
    expect_no_req = 1'b0;
    Stall_D = 1'b0;
    d0 = delivered;
    repeat (8) cycle();
    chk("t2_no_gap", 32'(delivered - d0), 32'd7);

    // 3: redirect with two requests outstanding.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle();
      if (pend_addr.size() == 2 && !Imem_RValid) found = 1'b1;
    end
    chk("t3_two_inflight", {31'b0, found}, 32'd1);
    PCTarget_E = 32'h100; PCSrc_E = 1'b1;
    cycle();
    PCSrc_E = 1'b0;
    chk("t3_bubble", {31'b0, Valid_D}, 32'd0);
    d0 = delivered;
    for (int i = 0; i < 12 && delivered == d0; i++) cycle();
    chk("t3_resume", 32'(delivered > d0), 32'd1);

    // 4: flush and stall together.
    lat_min = 1; lat_max = 1;
    repeat (6) cycle();
    Imem_Ready = 1'b0; Stall_D = 1'b1; Flush_D = 1'b1;
    addr0 = Imem_Addr;
    cycle();
    Stall_D = 1'b0; Flush_D = 1'b0; Imem_Ready = 1'b1;
    chk("t4_valid", {31'b0, Valid_D}, 32'd0);
    chk("t4_instr", Instr_D, NOP);
    chk("t4_pcf", Imem_Addr, addr0);
    repeat (4) cycle();

    // 5: random ready, latency, stalls, flushes and redirects.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      Imem_Ready = 1'($urandom % 2);
      Stall_D    = (($urandom % 5) == 0);
      Flush_D    = (($urandom % 20) == 0);
      if (($urandom % 30) == 0) begin
        PCSrc_E    = 1'b1;
        PCTarget_E = $urandom & 32'hFFFF_FFFC;
      end else begin
        PCSrc_E = 1'b0;
      end
      cycle();
    end
    PCSrc_E = 1'b0; Stall_D = 1'b0; Flush_D = 1'b0; Imem_Ready = 1'b1;
    d0 = delivered;
    repeat (20) cycle();
    chk("t5_drain", 32'(delivered > d0), 32'd1);

    // 6: wrap-around fetch sequence, then asynchronous reset mid-stream.
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (8) cycle();
    chk("t6_nacc", 32'(acc2.size() >= 3), 32'd1);
    if (acc2.size() >= 3) begin
      chk("t6_fetch0", acc2[0], 32'hFFFF_FFF8);
      chk("t6_fetch1", acc2[1], 32'hFFFF_FFFC);
      chk("t6_fetch2", acc2[2], 32'h0000_0000);
    end
    @(negedge clk);
    #2;
    chk("t6_pre_valid", {31'b0, Valid_D}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", {31'b0, Valid_D}, 32'd0);
    chk("t6_async_instr", Instr_D, NOP);
    chk("t6_async_addr", Imem_Addr, 32'd0);
    chk("t6_async_req", {31'b0, Imem_Req}, 32'd0);
    chk("t6_async_valid2", {31'b0, Valid_D2}, 32'd0);
    chk("t6_async_addr2", Imem_Addr2, RST_PC2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
